// File: rtl/relay_credit_sender.sv
// ---------------------------------------------------------------------------
// relay_credit_sender
//
// Transmit end of a credit-based stream link. Producers see a relay-station
// style write port (if_full_n / if_write / if_din). Accepted words sit in a
// 2-entry FIFO and are forwarded onto a freely pipelined link only while the
// remote receiver has free buffer slots, tracked by a credit counter. The
// receiver returns one link_credit pulse per slot it frees.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   if_full_n    out  registered; 1 = a write this cycle is accepted
//   if_write_ce  in   write clock enable
//   if_write     in   write request
//   if_din       in   write data [DATA_WIDTH]
//   link_valid   out  registered; one word on the link this cycle
//   link_data    out  registered payload [DATA_WIDTH]
//   link_credit  in   one returned credit per cycle it is high
//   credit_cnt   out  current available credits [CNT_WIDTH]
//   state_o      out  0 IDLE, 1 ACTIVE, 2 STALL (observational only)
//   err          out  sticky credit-overflow flag
// ---------------------------------------------------------------------------
module relay_credit_sender #(
    parameter int  DATA_WIDTH = 32,
    parameter int  CREDITS    = 8,
    localparam int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  link_credit,
    output logic [CNT_WIDTH-1:0]  credit_cnt,
    output logic [1:0]            state_o,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CREDITS_MAX = CNT_WIDTH'(CREDITS);
    // One extra bit so cnt + credit can exceed CREDITS without wrapping.
    localparam logic [CNT_WIDTH:0]   CREDITS_EXT = (CNT_WIDTH + 1)'(CREDITS);

    // Registered state
    logic [1:0]            occ_q,        occ_d;
    logic                  wr_ptr_q,     wr_ptr_d;
    logic                  rd_ptr_q,     rd_ptr_d;
    logic                  full_n_q,     full_n_d;
    logic                  link_valid_q, link_valid_d;
    logic [DATA_WIDTH-1:0] link_data_q,  link_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;
    logic                  err_q,        err_d;
    state_t                state_q,      state_d;

    // Combinational helpers
    logic                  push;
    logic                  send;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic                  overflow;

    // -----------------------------------------------------------------------
    // Two-entry storage. Each slot is written only when the write pointer
    // selects it, so order is preserved even when push and pop coincide.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
        logic [DATA_WIDTH-1:0] entry_q;

        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == 1'(gi))) begin
                entry_q <= if_din;
            end
        end
    end

    assign head = rd_ptr_q ? gen_entry[1].entry_q : gen_entry[0].entry_q;

    // -----------------------------------------------------------------------
    // Datapath / counter next-state
    // -----------------------------------------------------------------------
    always_comb begin
        push         = if_write & if_write_ce & full_n_q;
        // Forwarding uses only current registers: a word pushed into an empty
        // buffer waits one cycle (no bypass).
        send         = (occ_q != 2'd0) && (cnt_q != '0);

        occ_d        = occ_q;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ send;
        link_valid_d = send;
        link_data_d  = link_data_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        overflow     = 1'b0;

        if (push && !send) begin
            occ_d = occ_q + 2'd1;
        end else if (send && !push) begin
            occ_d = occ_q - 2'd1;
        end

        if (send) begin
            link_data_d = head;
        end

        // send implies cnt_q > 0, so the subtraction cannot underflow.
        cnt_sum = ({1'b0, cnt_q} + (CNT_WIDTH + 1)'(link_credit))
                  - (CNT_WIDTH + 1)'(send);

        // A credit beyond the receiver's buffer depth means the two ends have
        // lost agreement; clamp and flag it rather than wrap.
        if (cnt_sum > CREDITS_EXT) begin
            overflow = 1'b1;
            cnt_d    = CREDITS_MAX;
        end else begin
            cnt_d    = cnt_sum[CNT_WIDTH-1:0];
        end

        if (overflow) begin
            err_d = 1'b1;
        end

        full_n_d = (occ_d < 2'd2);
    end

    // -----------------------------------------------------------------------
    // Observational FSM, derived from next-state occupancy and credits.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = ST_ACTIVE;
        if ((occ_d == 2'd0) && (cnt_d == CREDITS_MAX)) begin
            state_d = ST_IDLE;
        end else if ((occ_d != 2'd0) && (cnt_d == '0)) begin
            state_d = ST_STALL;
        end
    end

    // -----------------------------------------------------------------------
    // Registers. Reset discards buffered words and ignores link_credit; the
    // receiver is expected to be reset in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            full_n_q     <= 1'b0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            cnt_q        <= CREDITS_MAX;
            err_q        <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_n_q     <= full_n_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            state_q      <= state_d;
        end
    end

    assign if_full_n  = full_n_q;
    assign link_valid = link_valid_q;
    assign link_data  = link_data_q;
    assign credit_cnt = cnt_q;
    assign state_o    = state_q;
    assign err        = err_q;

endmodule

// File: tb/tb_relay_credit_sender.sv
// ---------------------------------------------------------------------------
// tb_relay_credit_sender
//
// Scoreboard bench for relay_credit_sender. A sampler at every clock edge
// records accepted writes into an expected-word queue and advances a small
// arithmetic model (occupancy = accepted - sent, credits = CREDITS - sent +
// returned, clamped). A monitor then compares every registered output and
// pops the queue whenever a word appears on the link. The driver runs the
// directed scenarios followed by a randomized phase with a receiver model
// that returns credits after random delays.
// ---------------------------------------------------------------------------
module tb_relay_credit_sender;

    localparam int DW      = 32;
    localparam int CREDITS = 8;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clk;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          link_credit;
    logic [CW-1:0] credit_cnt;
    logic [1:0]    state_o;
    logic          err;

    int tests = 0;
    int fails = 0;

    relay_credit_sender #(
        .DATA_WIDTH (DW),
        .CREDITS    (CREDITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_full_n   (if_full_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .link_valid  (link_valid),
        .link_data   (link_data),
        .link_credit (link_credit),
        .credit_cnt  (credit_cnt),
        .state_o     (state_o),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard and reference model
    // -----------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    int            cnt_m     = CREDITS;
    int            occ_after = 0;
    bit            err_m     = 0;
    bit            full_m    = 0;
    bit            snd_m     = 0;
    logic [DW-1:0] data_m    = '0;
    int            words_seen = 0;

    initial begin
        bit            r, c, wr;
        logic [DW-1:0] din, w;
        int            tmp, st;
        forever begin
            @(posedge clk);
            r   = reset;
            c   = link_credit;
            wr  = if_write & if_write_ce;
            din = if_din;
            if (r) begin
                exp_q.delete();
                cnt_m     = CREDITS;
                err_m     = 0;
                full_m    = 0;
                snd_m     = 0;
                data_m    = '0;
                occ_after = 0;
            end else begin
                snd_m = (exp_q.size() > 0) && (cnt_m > 0);
                occ_after = exp_q.size() - (snd_m ? 1 : 0) + ((wr && full_m) ? 1 : 0);
                if (wr && full_m) exp_q.push_back(din);
                tmp = cnt_m - (snd_m ? 1 : 0) + (c ? 1 : 0);
                if (tmp > CREDITS) begin
                    err_m = 1;
                    tmp   = CREDITS;
                end
                cnt_m  = tmp;
                full_m = (occ_after < 2);
            end
            #2;
            chk("link_valid", 64'(link_valid), 64'(snd_m));
            if (snd_m) begin
                w      = exp_q.pop_front();
                data_m = w;
                if (link_valid) begin
                    words_seen++;
                    $display("[TB] link word %0d: data=0x%08h expected=0x%08h credits=%0d",
                             words_seen, link_data, w, credit_cnt);
                end
            end
            chk("link_data", 64'(link_data), 64'(data_m));
            chk("credit_cnt", 64'(credit_cnt), 64'(cnt_m));
            chk("if_full_n", 64'(if_full_n), 64'(full_m));
            chk("err", 64'(err), 64'(err_m));
            if (occ_after == 0 && cnt_m == CREDITS)  st = 0;
            else if (occ_after > 0 && cnt_m == 0)    st = 2;
            else                                     st = 1;
            chk("state_o", 64'(state_o), 64'(st));
        end
    end

    // -----------------------------------------------------------------------
    // Driver helpers: inputs change 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        bit acc;
        bit done = 0;
        if_din      = w;
        if_write    = 1'b1;
        if_write_ce = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            acc = if_full_n;
            tick();
            if (acc) done = 1;
        end
        if (!done) chk("write_accept_timeout", 64'd0, 64'd1);
        if_write = 1'b0;
    endtask

    task automatic credits(input int n);
        for (int k = 0; k < n; k++) begin
            link_credit = 1'b1;
            tick();
        end
        link_credit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Random-phase receiver model: credit return times, nondecreasing.
    int due_q[$];

    initial begin
        int cyc;
        int last_due;
        int d;
        reset       = 1'b1;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_din      = '0;
        link_credit = 1'b0;

        // Reset state
        idle(3);
        chk("rst_full_n", 64'(if_full_n), 64'd0);
        chk("rst_valid", 64'(link_valid), 64'd0);
        chk("rst_cnt", 64'(credit_cnt), 64'(CREDITS));
        chk("rst_state", 64'(state_o), 64'd0);
        reset = 1'b0;
        tick();
        chk("first_full_n", 64'(if_full_n), 64'd1);

        // Basic send: 2 cycles write-to-link, no bypass
        if_din = 32'hA5; if_write = 1'b1; if_write_ce = 1'b1;
        tick();
        if_write = 1'b0;
        chk("basic_nobypass", 64'(link_valid), 64'd0);
        tick();
        chk("basic_valid", 64'(link_valid), 64'd1);
        chk("basic_data", 64'(link_data), 64'hA5);
        chk("basic_cnt", 64'(credit_cnt), 64'd7);
        chk("basic_state", 64'(state_o), 64'd1);
        credits(1);
        idle(2);

        // Credit exhaustion: 10 words, 8 credits
        for (int i = 0; i < 10; i++) write_word(DW'(i));
        idle(4);
        chk("exh_cnt", 64'(credit_cnt), 64'd0);
        chk("exh_state", 64'(state_o), 64'd2);
        chk("exh_full_n", 64'(if_full_n), 64'd0);

        // Resume: each credit releases one word
        credits(1);
        tick();
        chk("resume1_valid", 64'(link_valid), 64'd1);
        chk("resume1_data", 64'(link_data), 64'd8);
        credits(1);
        tick();
        chk("resume2_valid", 64'(link_valid), 64'd1);
        chk("resume2_data", 64'(link_data), 64'd9);
        credits(8);
        tick();
        chk("resume_idle", 64'(state_o), 64'd0);
        chk("resume_cnt", 64'(credit_cnt), 64'd8);

        // Simultaneous send and credit at cnt = 3
        for (int i = 0; i < 5; i++) write_word(DW'(32'h50 + i));
        idle(4);
        chk("sim_start_cnt", 64'(credit_cnt), 64'd3);
        if_din = 32'h100; if_write = 1'b1; if_write_ce = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if_din      = DW'(32'h101 + i);
            link_credit = 1'b1;
            tick();
            chk("sim_cnt", 64'(credit_cnt), 64'd3);
            chk("sim_valid", 64'(link_valid), 64'd1);
        end
        if_write    = 1'b0;
        link_credit = 1'b0;
        idle(3);
        credits(6);
        tick();
        chk("sim_refill_cnt", 64'(credit_cnt), 64'd8);

        // Overflow: credit into a full counter
        credits(1);
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_cnt", 64'(credit_cnt), 64'd8);
        idle(3);
        chk("ovf_sticky", 64'(err), 64'd1);

        // Reset mid-stream with buffered words and credits in flight
        for (int i = 0; i < 10; i++) write_word(DW'(32'h200 + i));
        idle(3);
        credits(1);
        reset       = 1'b1;
        link_credit = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(link_valid), 64'd0);
        chk("mid_rst_full_n", 64'(if_full_n), 64'd0);
        chk("mid_rst_cnt", 64'(credit_cnt), 64'd8);
        chk("mid_rst_err", 64'(err), 64'd0);
        reset       = 1'b0;
        link_credit = 1'b0;
        tick();
        chk("mid_rel_full_n", 64'(if_full_n), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_stale", 64'(link_valid), 64'd0);
        end

        // Randomized phase with a delayed-credit receiver
        cyc      = 0;
        last_due = 0;
        for (int k = 0; k < 400; k++) begin
            if_write    = ($urandom_range(0, 3) != 0);
            if_write_ce = ($urandom_range(0, 7) != 0);
            if_din      = $urandom;
            link_credit = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                link_credit = 1'b1;
                void'(due_q.pop_front());
            end
            tick();
            cyc++;
            if (link_valid) begin
                d = cyc + $urandom_range(1, 6);
                if (d < last_due) d = last_due;
                last_due = d;
                due_q.push_back(d);
            end
        end

        // Drain and return all remaining credits
        if_write = 1'b0;
        for (int k = 0; k < 300 && (due_q.size() > 0 || exp_q.size() > 0); k++) begin
            link_credit = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                link_credit = 1'b1;
                void'(due_q.pop_front());
            end
            tick();
            cyc++;
            if (link_valid) begin
                d = cyc + $urandom_range(1, 6);
                if (d < last_due) d = last_due;
                last_due = d;
                due_q.push_back(d);
            end
        end
        link_credit = 1'b0;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_credits", 64'(due_q.size()), 64'd0);
        idle(2);
        chk("final_cnt", 64'(credit_cnt), 64'(CREDITS));
        chk("final_state", 64'(state_o), 64'd0);
        chk("final_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
